// File: rtl/dog_anim_ctrl_if.sv
// dog_anim_ctrl_if: groups the VGA coordinates, playback commands and the
// sequencer status outputs shared between a host and dog_anim_ctrl.
interface dog_anim_ctrl_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       start;
  logic       pause;
  logic       stop;
  logic       loop_en;
  logic [2:0] frame_sel;
  logic       busy;
  logic       done;
  logic       frame_tick;

  modport master (
    output DrawX, DrawY, blank, start, pause, stop, loop_en,
    input  frame_sel, busy, done, frame_tick
  );

  modport slave (
    input  DrawX, DrawY, blank, start, pause, stop, loop_en,
    output frame_sel, busy, done, frame_tick
  );
endinterface

// File: rtl/dog_anim_ctrl.sv
// dog_anim_ctrl: animation sequencer for the dog sprite set. Advances
// frame_sel once every HOLD_FRAMES screen frames, and only on the cycle where
// the beam leaves the visible area, so the sprite mux never tears.
// Optional macro DOG_ANIM_PINGPONG_EN: sweep up then back down instead of
// wrapping; one-shot sequences then finish back at frame 0.
module dog_anim_ctrl #(
  parameter int NUM_FRAMES  = 6,
  parameter int HOLD_FRAMES = 8
) (
  input  logic           vga_clk,
  input  logic           reset_n,
  dog_anim_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  localparam logic [2:0] LAST_FRAME = 3'(NUM_FRAMES - 1);
  localparam logic [7:0] LAST_HOLD  = 8'(HOLD_FRAMES - 1);

  state_t     state, state_n;
  logic [7:0] hold_cnt, hold_n;
  logic [2:0] frame_q, frame_n;
  logic       zero_pend, zero_n;
  logic       loop_q, loop_n;
  logic       done_q, done_n;
  logic       tick_q;
  logic       tick_raw;
  logic       blank_unused;

`ifdef DOG_ANIM_PINGPONG_EN
  logic       dir_down, dir_n;
`endif

  assign tick_raw     = (bus.DrawX == 10'd639) && (bus.DrawY == 10'd479);
  assign blank_unused = bus.blank;

  assign bus.frame_sel  = frame_q;
  assign bus.busy       = (state == PLAY) || (state == PAUSE);
  assign bus.done       = done_q;
  assign bus.frame_tick = tick_q;

  // Evaluate the tick against the current state first, then let any command override it.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    frame_n = frame_q;
    zero_n  = zero_pend;
    loop_n  = loop_q;
    done_n  = 1'b0;
`ifdef DOG_ANIM_PINGPONG_EN
    dir_n   = dir_down;
`endif

    if (tick_raw) begin
      if (zero_pend) begin
        frame_n = '0;
        zero_n  = 1'b0;
      end else if (state == PLAY) begin
        if (hold_cnt != LAST_HOLD) begin
          hold_n = hold_cnt + 8'd1;
        end else begin
          hold_n = '0;
`ifdef DOG_ANIM_PINGPONG_EN
          if (!dir_down) begin
            if (frame_q == LAST_FRAME) begin
              frame_n = LAST_FRAME - 3'd1;
              dir_n   = 1'b1;
            end else begin
              frame_n = frame_q + 3'd1;
            end
          end else begin
            frame_n = frame_q - 3'd1;
          end
          if (dir_n && (frame_n == 3'd0)) begin
            if (loop_q) begin
              dir_n = 1'b0;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
`else
          if (frame_q == LAST_FRAME) begin
            if (loop_q) begin
              frame_n = '0;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            frame_n = frame_q + 3'd1;
          end
`endif
        end
      end
    end

    if (bus.stop || bus.start) begin
      hold_n = '0;
`ifdef DOG_ANIM_PINGPONG_EN
      dir_n  = 1'b0;
`endif
      if (tick_raw) begin
        frame_n = '0;
        zero_n  = 1'b0;
      end else begin
        zero_n  = 1'b1;
      end
      if (bus.stop) begin
        state_n = IDLE;
      end else begin
        state_n = PLAY;
        loop_n  = bus.loop_en;
      end
    end else if (bus.pause) begin
      if (state_n == PLAY) begin
        state_n = PAUSE;
      end else if (state_n == PAUSE) begin
        state_n = PLAY;
      end
    end
  end

  // Sequencer registers and the registered end-of-visible-area pulse.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      frame_q   <= '0;
      zero_pend <= 1'b0;
      loop_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      frame_q   <= frame_n;
      zero_pend <= zero_n;
      loop_q    <= loop_n;
      done_q    <= done_n;
      tick_q    <= tick_raw;
    end
  end

`ifdef DOG_ANIM_PINGPONG_EN
  // Sweep direction register; low means counting up.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_down <= 1'b0;
    end else begin
      dir_down <= dir_n;
    end
  end
`endif

endmodule

// File: doc/dog_anim_ctrl.md
# dog_anim_ctrl

Animation sequencer for the six-frame dog sprite set (frames 0–5, each a ROM plus palette sprite renderer driven by DrawX/DrawY on vga_clk). It tracks screen-frame boundaries from the VGA draw coordinates. It advances a frame index at a programmable hold rate and exposes play, pause and stop control. Frame changes happen only at end of the visible area, so the sprite mux downstream never tears mid-frame.

## Interface
- NUM_FRAMES, 6: number of animation frames; frame_sel counts 0..NUM_FRAMES-1; legal range 2..8.
- HOLD_FRAMES, 8: screen frames each animation frame is held; legal range 1..255.
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column (0..799).
- DrawY  in  10  current pixel row (0..524).
- blank  in  1  high during the visible area; informational only, not used for tick generation.
- start  in  1  one-cycle command: begin or restart playback from frame 0.
- pause  in  1  one-cycle command: toggle between PLAY and PAUSE.
- stop  in  1  one-cycle command: abort playback and return to frame 0.
- loop_en  in  1  1 = wrap continuously; 0 = one-shot. Sampled at start.
- frame_sel  out  3  animation frame index driven to the sprite mux.
- busy  out  1  high in PLAY or PAUSE.
- done  out  1  one-cycle pulse when a one-shot sequence completes.
- frame_tick  out  1  registered one-cycle pulse marking end of visible area.

## Operation
- Tick: tick_raw = (DrawX==639 && DrawY==479). frame_tick is tick_raw registered one cycle later.
- All frame_sel and hold_cnt updates occur on the edge where tick_raw is high.
- hold_cnt is 8 bits and is internal.
- States:
  - IDLE: no advance.
  - PLAY: advance at ticks.
  - PAUSE: frozen.
  - DONE: one-shot finished.
- Command priority: stop > start > pause. Lower-priority commands asserted in the same cycle are dropped.
- start, from any state:
  - Go to PLAY; latch loop_en into loop_q; clear hold_cnt.
  - Set zero_pend, which forces frame_sel to 0 at the next tick.
  - The tick that consumes zero_pend does not count toward hold.
- stop, from any state: go to IDLE; clear hold_cnt; set zero_pend.
- pause: PLAY→PAUSE, PAUSE→PLAY. Ignored in IDLE and DONE. hold_cnt is preserved.
- PLAY at a tick:
  - If hold_cnt == HOLD_FRAMES-1: clear hold_cnt and advance frame_sel. Otherwise hold_cnt += 1.
  - Advance from NUM_FRAMES-1 with loop_q=1: frame_sel becomes 0.
  - Advance from NUM_FRAMES-1 with loop_q=0: frame_sel stays at NUM_FRAMES-1; go to DONE; done pulses for that one edge.
- zero_pend is cleared at the tick where it applies, in every state.
- frame_sel is never driven to a value ≥ NUM_FRAMES.

## Timing
- Reset (reset_n low, asynchronous):
  - Outputs: frame_sel=0, busy=0, done=0, frame_tick=0.
  - Internal: state=IDLE, hold_cnt=0, zero_pend=0, loop_q=0.
- Command to state: one cycle. busy reflects the new state on the edge after the command.
- frame_sel changes only on tick_raw edges. It is stable from DrawY=479/DrawX=639 through the entire next visible frame.
- A command arriving in the same cycle as tick_raw:
  - The command's state change applies.
  - The tick is evaluated against the pre-command state, except zero_pend, which applies on that tick.
- Playback cadence: one full loop = NUM_FRAMES × HOLD_FRAMES screen frames.
- Reset asserted mid-playback returns all outputs to reset values immediately. No done pulse is emitted.

## Configuration
- DOG_ANIM_PINGPONG_EN defined:
  - Adds a direction register dir (reset = up).
  - Sequence runs 0..NUM_FRAMES-1..0: reversal at NUM_FRAMES-1 and at 0, and end frames are not repeated.
  - One-shot completes when the down-sweep reaches 0, which sets frame_sel=0 and pulses done.
  - start and stop set dir = up.
- Undefined:
  - Wrap-around sequence only; no dir register is synthesized.

## Test plan
- Reset/idle: reset_n low mid-run, then release, then drive 3 ticks with no command → frame_sel=0, busy=0, done never pulses.
- Loop cadence: HOLD_FRAMES=2, start with loop_en=1, then 14 ticks → first tick zeroes; frame_sel sequence 0,0,1,1,2,2,3,3,4,4,5,5,0 (wrap); frame_tick pulses one cycle after each tick_raw.
- One-shot: HOLD_FRAMES=1, loop_en=0, start then 7 ticks → frame_sel 0,1,2,3,4,5; done pulses exactly once at the 7th tick; state DONE; frame_sel holds 5; busy=0.
- Pause/stop: during PLAY at frame 3, pause then 4 ticks → frame_sel stays 3. pause again → resumes with hold_cnt preserved. stop → busy=0 next cycle; frame_sel=0 only at the following tick.
- Collision: start and stop in the same cycle as tick_raw → stop wins; state IDLE; frame_sel=0 on that tick.
- Ping-pong (macro defined): HOLD_FRAMES=1, loop_en=0 → frame_sel 0,1,2,3,4,5,4,3,2,1,0; then done pulses.
